log_sprite_loader: RTL and testbench
====================================

// Module: log_sprite_loader
// PURPOSE
//  Write-side companion of the log sprite source. Accepts commands from the
//  processor MMIO slot and serialises them into the sprite RAM write port
//  (we / addr_w / pixel_in), one 2-bit pixel per clk.
//  A packed 32-bit word carries 16 pixels. A fill command writes N copies of one pixel.
//  The block frees firmware from issuing one bus write per pixel during level load.
// PARAMETERS
//  ADDR  13  sprite RAM address bits ({id[1:0], y[4:0], x[5:0]}, 4 sprites x 64x32)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       block can accept a command
//  cmd_op     in   2       00 SET_ADDR, 01 WRITE_WORD, 10 FILL, 11 reserved
//  cmd_data   in   32      command payload
//  we         out  1       sprite RAM write enable
//  addr_w     out  ADDR    sprite RAM write address
//  pixel_in   out  2       sprite RAM write data (palette code)
//  busy       out  1       high while in SHIFT or FILL
//  done_tick  out  1       one-cycle pulse on the last write of a WORD/FILL
//  checksum   out  16      running pixel sum (see CONFIGURATION)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous, active-high.
//  - Reset values: cmd_ready=0 (during reset), we=0, addr_w=0, pixel_in=0,
//    busy=0, done_tick=0, checksum=0. Internal write pointer ptr=0. State=IDLE.
//  - States: IDLE, SHIFT, FILL.
//    cmd_ready = (state==IDLE) & ~reset. A transfer occurs when cmd_valid & cmd_ready.
//  - we, addr_w, pixel_in, done_tick are registered. When we=0, addr_w and pixel_in hold their last values.
//  - SET_ADDR (accepted at cycle t):
//    ptr <= cmd_data[ADDR-1:0]. No RAM write. The block stays in IDLE.
//  - WRITE_WORD (accepted at cycle t):
//    sh <= cmd_data; cnt <= 0; state goes to SHIFT.
//    For cycles t+1..t+16: we=1, addr_w=ptr, pixel_in=sh[1:0] (pixel order LSB first).
//    After each write: sh>>=2 and ptr<=ptr+1.
//    done_tick=1 at t+16. Return to IDLE; cmd_ready=1 again at t+17.
//  - FILL (accepted at cycle t): value=cmd_data[1:0]; N=cmd_data[31:16].
//    For N>0: we=1 at t+1..t+N, each writing value at ptr, then ptr++.
//    done_tick at t+N; cmd_ready at t+N+1.
//    For N=0: no writes; done_tick at t+1; cmd_ready at t+2.
//  - op 11: accepted and ignored; the block stays in IDLE with no outputs changed.
//  - ptr wraps modulo 2^ADDR (e.g. 0x1FFF -> 0x0000), with no error indication.
//  - busy = (state!=IDLE). It is 1 on exactly the cycles where we may be 1.
//  - cmd_data/cmd_op are ignored while cmd_ready=0. The sender must hold them
//    stable until the transfer completes.
//  - Reset mid-SHIFT/FILL aborts the command: we=0 in the cycle after reset is sampled,
//    remaining pixels are dropped, no done_tick is issued, and ptr=0.
//  - Back-to-back commands: IDLE lasts at least one cycle between commands,
//    so throughput is 16 pixels per 17 cycles.
// CONFIGURATION
//  Macro LOG_LOADER_CHECKSUM_EN:
//  - Defined: checksum accumulates the 16-bit sum (wrapping) of every pixel_in
//    written with we=1. It is cleared to 0 by reset and by SET_ADDR.
//    It updates in the cycle after each write.
//  - Undefined: checksum is tied to 16'h0000 and no accumulator logic is built.
// TESTING
//  1. SET_ADDR 0x0040, WRITE_WORD 0xE4E4E4E4 -> 16 writes at addr 0x040..0x04F
//     with pixels 0,1,2,3 repeating; done_tick on the 16th write;
//     checksum=0x0018 (macro on).
//  2. SET_ADDR 0x1FFE, WRITE_WORD 0x0000000F -> addr 0x1FFE=3, 0x1FFF=3,
//     then 0x0000..0x000D=0 (wrap-around).
//  3. FILL with cmd_data=0x00050002 after SET_ADDR 0x0100 -> 5 writes of 2
//     at 0x100..0x104; done_tick at t+5; cmd_ready=0 during t+1..t+5.
//  4. FILL with N=0 -> no we; done_tick at t+1; op 11 -> no we, no done_tick.
//  5. Assert reset at the 7th write of a WRITE_WORD -> we=0 next cycle, no done_tick;
//     then WRITE_WORD writes from addr 0x000.
//  6. Hold cmd_valid high with 3 queued WRITE_WORDs -> accepted at t, t+17, t+34;
//     writes are contiguous in address.

Source files
------------

// File: rtl/log_sprite_loader.sv
// ============================================================================
// Module   : log_sprite_loader
// Brief    : Serialises MMIO commands (SET_ADDR / WRITE_WORD / FILL) into the
//            sprite RAM write port, one 2-bit pixel per clock.
//            Optional running pixel checksum: LOG_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_sprite_loader #(
  parameter int ADDR = 13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [31:0]     cmd_data,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic [1:0]      pixel_in,
  output logic            busy,
  output logic            done_tick,
  output logic [15:0]     checksum
);

  localparam logic [1:0] C_OP_SET_ADDR   = 2'b00;
  localparam logic [1:0] C_OP_WRITE_WORD = 2'b01;
  localparam logic [1:0] C_OP_FILL       = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  state_t          state_q;
  logic [ADDR-1:0] ptr_q;
  logic [31:0]     sh_q;
  logic [1:0]      fill_val_q;
  logic [15:0]     rem_q;
  logic            we_q;
  logic            done_q;
  logic [ADDR-1:0] addr_q;
  logic [1:0]      pix_q;

  logic            w_accept;
  logic [15:0]     w_fill_n;
  logic [1:0]      w_next_pix;
  logic            w_unused_data;

  assign cmd_ready     = (state_q == ST_IDLE) & ~reset;
  assign w_accept      = cmd_valid & cmd_ready;
  assign w_fill_n      = cmd_data[31:16];
  assign w_next_pix    = (state_q == ST_SHIFT) ? sh_q[1:0] : fill_val_q;
  assign w_unused_data = ^cmd_data;

  // The first pixel of a command is issued on the accepting edge, so rem_q
  // counts the writes still outstanding after the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sh_q       <= '0;
      fill_val_q <= '0;
      rem_q      <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      pix_q      <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            case (cmd_op)
              C_OP_SET_ADDR: begin
                ptr_q <= cmd_data[ADDR-1:0];
              end
              C_OP_WRITE_WORD: begin
                state_q <= ST_SHIFT;
                we_q    <= 1'b1;
                addr_q  <= ptr_q;
                pix_q   <= cmd_data[1:0];
                sh_q    <= {2'b00, cmd_data[31:2]};
                ptr_q   <= ptr_q + ADDR'(1);
                rem_q   <= 16'd15;
              end
              C_OP_FILL: begin
                state_q    <= ST_FILL;
                fill_val_q <= cmd_data[1:0];
                if (w_fill_n == 16'd0) begin
                  done_q <= 1'b1;
                  rem_q  <= 16'd0;
                end else begin
                  we_q   <= 1'b1;
                  addr_q <= ptr_q;
                  pix_q  <= cmd_data[1:0];
                  ptr_q  <= ptr_q + ADDR'(1);
                  rem_q  <= w_fill_n - 16'd1;
                  done_q <= (w_fill_n == 16'd1);
                end
              end
              default: begin
              end
            endcase
          end
        end
        default: begin
          if (rem_q != 16'd0) begin
            we_q   <= 1'b1;
            addr_q <= ptr_q;
            pix_q  <= w_next_pix;
            sh_q   <= {2'b00, sh_q[31:2]};
            ptr_q  <= ptr_q + ADDR'(1);
            rem_q  <= rem_q - 16'd1;
            done_q <= (rem_q == 16'd1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign we        = we_q;
  assign addr_w    = addr_q;
  assign pixel_in  = pix_q;
  assign done_tick = done_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef LOG_LOADER_CHECKSUM_EN
  logic [15:0] chk_q;
  logic [15:0] chk_d;

  always_comb begin
    chk_d = chk_q;
    if (w_accept && (cmd_op == C_OP_SET_ADDR)) begin
      chk_d = 16'h0000;
    end else if (we_q) begin
      chk_d = chk_q + {14'd0, pix_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= 16'h0000;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_log_sprite_loader.sv
// ============================================================================
// Module   : tb_log_sprite_loader
// Brief    : Directed self-checking bench for log_sprite_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_log_sprite_loader;

  localparam int ADDR = 13;
  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_WORD = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [31:0]     cmd_data;
  logic            we;
  logic [ADDR-1:0] addr_w;
  logic [1:0]      pixel_in;
  logic            busy;
  logic            done_tick;
  logic [15:0]     checksum;

  log_sprite_loader #(.ADDR(ADDR)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .we        (we),
    .addr_w    (addr_w),
    .pixel_in  (pixel_in),
    .busy      (busy),
    .done_tick (done_tick),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int              n_wr = 0;
  int              n_done = 0;
  int              bad_busy = 0;
  logic [ADDR-1:0] wr_addr [256];
  logic [1:0]      wr_pix  [256];
  int              wr_cyc  [256];
  int              done_cyc[64];

  // Write/done log, sampled mid-cycle
  always @(negedge clk) begin
    if (we && n_wr < 256) begin
      wr_addr[n_wr] <= addr_w;
      wr_pix[n_wr]  <= pixel_in;
      wr_cyc[n_wr]  <= cyc;
      n_wr          <= n_wr + 1;
    end
    if (done_tick && n_done < 64) begin
      done_cyc[n_done] <= cyc;
      n_done           <= n_done + 1;
    end
    if ((we && !busy) || (busy && cmd_ready)) bad_busy <= bad_busy + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_ready(output int c);
    int k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    c = cyc;
  endtask

  // Called just after a negedge; returns just after the negedge of t+1.
  task automatic send(input logic [1:0] op, input logic [31:0] d, output int acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    wait_ready(acc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int acc, input int exp_off, input string tag);
    int c;
    wait_ready(c);
    check_eq(tag, c - acc, exp_off);
  endtask

  function automatic logic [31:0] chk_exp(input logic [31:0] v);
`ifdef LOG_LOADER_CHECKSUM_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  int          acc;
  int          b;
  int          bd;
  int          accs[3];
  logic [31:0] wdat[3];

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 32'd0;
    tick(3);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("rst_we",    {31'd0, we}, 32'd0);
    check_eq("rst_addr",  {19'd0, addr_w}, 32'd0);
    check_eq("rst_pix",   {30'd0, pixel_in}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_done",  {31'd0, done_tick}, 32'd0);
    check_eq("rst_chk",   {16'd0, checksum}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    tick(1);

    // 1: word at 0x040, pixels 0,1,2,3 repeating
    send(OP_SET, 32'h0000_0040, acc);
    check_eq("t1_set_busy", {31'd0, busy}, 32'd0);
    b = n_wr; bd = n_done;
    send(OP_WORD, 32'hE4E4_E4E4, acc);
    wait_idle(acc, 17, "t1_ready_cyc");
    tick(1);
    check_eq("t1_nwr", n_wr - b, 16);
    for (int i = 0; i < 16; i++) begin
      check_eq("t1_addr", {19'd0, wr_addr[b+i]}, (32'h40 + i) & 32'h1FFF);
      check_eq("t1_pix",  {30'd0, wr_pix[b+i]}, i % 4);
      check_eq("t1_cyc",  wr_cyc[b+i], acc + 1 + i);
    end
    check_eq("t1_ndone", n_done - bd, 1);
    check_eq("t1_done_cyc", done_cyc[bd], acc + 16);
    check_eq("t1_chk", {16'd0, checksum}, chk_exp(32'h18));

    // 2: address wrap
    send(OP_SET, 32'h0000_1FFE, acc);
    b = n_wr;
    send(OP_WORD, 32'h0000_000F, acc);
    wait_idle(acc, 17, "t2_ready_cyc");
    tick(1);
    check_eq("t2_nwr", n_wr - b, 16);
    for (int i = 0; i < 16; i++) begin
      check_eq("t2_addr", {19'd0, wr_addr[b+i]}, (32'h1FFE + i) & 32'h1FFF);
      check_eq("t2_pix",  {30'd0, wr_pix[b+i]}, (i < 2) ? 32'd3 : 32'd0);
    end
    check_eq("t2_chk", {16'd0, checksum}, chk_exp(32'h6));

    // 3: fill 5 x value 2 at 0x100
    send(OP_SET, 32'h0000_0100, acc);
    b = n_wr; bd = n_done;
    send(OP_FILL, 32'h0005_0002, acc);
    wait_idle(acc, 6, "t3_ready_cyc");
    tick(1);
    check_eq("t3_nwr", n_wr - b, 5);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_addr", {19'd0, wr_addr[b+i]}, 32'h100 + i);
      check_eq("t3_pix",  {30'd0, wr_pix[b+i]}, 32'd2);
      check_eq("t3_cyc",  wr_cyc[b+i], acc + 1 + i);
    end
    check_eq("t3_ndone", n_done - bd, 1);
    check_eq("t3_done_cyc", done_cyc[bd], acc + 5);
    check_eq("t3_chk", {16'd0, checksum}, chk_exp(32'hA));

    // 4: fill N=0, reserved op, then fill N=1 continues at 0x105
    b = n_wr; bd = n_done;
    send(OP_FILL, 32'h0000_0003, acc);
    wait_idle(acc, 2, "t4_fill0_ready");
    tick(1);
    check_eq("t4_fill0_nwr", n_wr - b, 0);
    check_eq("t4_fill0_ndone", n_done - bd, 1);
    check_eq("t4_fill0_done_cyc", done_cyc[bd], acc + 1);
    b = n_wr; bd = n_done;
    send(OP_RSV, 32'hFFFF_FFFF, acc);
    wait_idle(acc, 1, "t4_rsv_ready");
    tick(2);
    check_eq("t4_rsv_nwr", n_wr - b, 0);
    check_eq("t4_rsv_ndone", n_done - bd, 0);
    b = n_wr; bd = n_done;
    send(OP_FILL, 32'h0001_0001, acc);
    wait_idle(acc, 2, "t4_fill1_ready");
    tick(1);
    check_eq("t4_fill1_nwr", n_wr - b, 1);
    check_eq("t4_fill1_addr", {19'd0, wr_addr[b]}, 32'h105);
    check_eq("t4_fill1_pix", {30'd0, wr_pix[b]}, 32'd1);
    check_eq("t4_fill1_done_cyc", done_cyc[bd], acc + 1);
    check_eq("t4_chk", {16'd0, checksum}, chk_exp(32'hB));

    // 5: reset during the 7th write aborts the word
    send(OP_SET, 32'h0000_0200, acc);
    b = n_wr; bd = n_done;
    send(OP_WORD, 32'hFFFF_FFFF, acc);
    while (cyc < acc + 7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_we_after_rst", {31'd0, we}, 32'd0);
    check_eq("t5_busy_after_rst", {31'd0, busy}, 32'd0);
    tick(3);
    check_eq("t5_nwr", n_wr - b, 7);
    check_eq("t5_ndone", n_done - bd, 0);
    check_eq("t5_chk", {16'd0, checksum}, 32'd0);
    b = n_wr;
    send(OP_WORD, 32'h0000_0001, acc);
    wait_idle(acc, 17, "t5_ready_cyc");
    tick(1);
    check_eq("t5_nwr2", n_wr - b, 16);
    check_eq("t5_addr0", {19'd0, wr_addr[b]}, 32'h0);
    check_eq("t5_pix0", {30'd0, wr_pix[b]}, 32'd1);
    check_eq("t5_addr1", {19'd0, wr_addr[b+1]}, 32'h1);
    check_eq("t5_pix1", {30'd0, wr_pix[b+1]}, 32'd0);
    check_eq("t5_addr15", {19'd0, wr_addr[b+15]}, 32'hF);

    // 6: three queued words with cmd_valid held high
    send(OP_SET, 32'h0000_0300, acc);
    b = n_wr; bd = n_done;
    wdat[0] = 32'h5555_5555;
    wdat[1] = 32'hAAAA_AAAA;
    wdat[2] = 32'hFFFF_FFFF;
    cmd_valid = 1'b1;
    cmd_op    = OP_WORD;
    for (int k = 0; k < 3; k++) begin
      cmd_data = wdat[k];
      wait_ready(accs[k]);
      @(posedge clk);
      #1;
      if (k == 2) cmd_valid = 1'b0;
      @(negedge clk);
    end
    wait_idle(accs[2], 17, "t6_ready_cyc");
    tick(1);
    check_eq("t6_acc1", accs[1] - accs[0], 17);
    check_eq("t6_acc2", accs[2] - accs[0], 34);
    check_eq("t6_nwr", n_wr - b, 48);
    for (int i = 0; i < 48; i++) begin
      check_eq("t6_addr", {19'd0, wr_addr[b+i]}, 32'h300 + i);
      check_eq("t6_pix",  {30'd0, wr_pix[b+i]}, (i / 16) + 1);
    end
    check_eq("t6_ndone", n_done - bd, 3);
    check_eq("t6_chk", {16'd0, checksum}, chk_exp(32'h60));

    check_eq("busy_consistency", bad_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
